// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes engine: LANES sbox instances walk the 16 state bytes, LSB slice first.
// Optional feature macro SUBBYTES_OVERLAP_EN adds a decoupled output register (IDLE/RUN/WAIT).

module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [7:0] SBOX_ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX_ROM[a_i];
endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NSTEP   = 16 / LANES;
  localparam int SLICE_W = LANES * 8;
  localparam int CNT_W   = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEP - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

`ifdef SUBBYTES_OVERLAP_EN
  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`endif

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [127:0]       work_q;
  logic [127:0]       work_d;
  logic [SLICE_W-1:0] slice_in;
  logic [SLICE_W-1:0] slice_out;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               last_step;
`ifdef SUBBYTES_OVERLAP_EN
  logic [127:0]       out_data_q;
  logic               slot_free;

  assign slot_free = !out_valid_q || out_ready;
`endif

  assign last_step = (cnt_q == LAST_CNT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slice_in = '0;
    for (int k = 0; k < NSTEP; k++) begin
      if (cnt_q == CNT_W'(k)) slice_in = work_q[k*SLICE_W +: SLICE_W];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox u_sbox (
      .a_i (slice_in[j*8 +: 8]),
      .y_o (slice_out[j*8 +: 8])
    );
  end

  // Only the current slice is replaced; bytes not yet visited pass through untouched.
  always_comb begin
    work_d = work_q;
    for (int k = 0; k < NSTEP; k++) begin
      if (cnt_q == CNT_W'(k)) work_d[k*SLICE_W +: SLICE_W] = slice_out;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the work register is reset too, so a block aborted by reset can never leak to out_data.
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUBBYTES_OVERLAP_EN
      out_data_q  <= '0;
`endif
    end else begin
`ifdef SUBBYTES_OVERLAP_EN
      // NOTE: a reload later in this block overrides this clear, since the last assignment wins.
      if (out_ready) out_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            work_q     <= in_data;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          work_q <= work_d;
          if (!last_step) begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef SUBBYTES_OVERLAP_EN
          end else if (slot_free) begin
            out_data_q  <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
`else
          end else begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
`endif
        end
`ifdef SUBBYTES_OVERLAP_EN
        WAIT: begin
          if (slot_free) begin
            out_data_q  <= work_q;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
`else
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
`ifdef SUBBYTES_OVERLAP_EN
  assign out_data  = out_data_q;
`else
  assign out_data  = work_q;
`endif

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LANES 4, 1, 16) checked against a GF(2^8) reference
// model through an expected-result queue; honours SUBBYTES_OVERLAP_EN for timing expectations.

module tb_sub_bytes_seq;
  localparam logic [127:0] ALL63    = {16{8'h63}};
  localparam logic [127:0] ALL53    = {16{8'h53}};
  localparam logic [127:0] ALLED    = {16{8'hed}};
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`ifdef SUBBYTES_OVERLAP_EN
  localparam int  B2B_GAP      = 5;
  localparam bit  HOLD_IN_RDY  = 1'b1;
`else
  localparam int  B2B_GAP      = 6;
  localparam bit  HOLD_IN_RDY  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         out_ready;
  logic [1:0]   sel;
  logic         in_valid_a  [3];
  logic [127:0] in_data_a   [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic [127:0] out_data_a  [3];
  logic         busy_a      [3];

  logic         cur_in_ready;
  logic         cur_out_valid;
  logic [127:0] cur_out_data;
  logic         cur_busy;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LANES_G = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    sub_bytes_seq #(.LANES(LANES_G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready),
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
  end

  assign cur_in_ready  = in_ready_a[sel];
  assign cur_out_valid = out_valid_a[sel];
  assign cur_out_data  = out_data_a[sel];
  assign cur_busy      = busy_a[sel];

  function automatic int lanes_of(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the AES affine transform.
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_sbox(d[i*8 +: 8]);
    return r;
  endfunction

  // Scoreboard consumer: every handshake on the selected instance pops one expected block.
  always @(negedge clk) begin
    if (!rst && cur_out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra lanes=%0d got %h expected none", lanes_of(sel), cur_out_data);
      end else begin
        if (cur_out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL sb_data lanes=%0d got %h expected %h", lanes_of(sel), cur_out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_block(input logic [127:0] d, input logic [127:0] e, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(posedge clk); #1;
    in_valid_a[sel] = 1'b1;
    in_data_a[sel]  = d;
    while (acc < 0 && n < 100) begin
      @(negedge clk);
      if (cur_in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        exp_q.push_back(e);
      end else begin
        n++;
      end
    end
    in_valid_a[sel] = 1'b0;
    in_data_a[sel]  = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout lanes=%0d got no accept expected accept", lanes_of(sel));
    end
  endtask

  task automatic wait_out(input int acc, input int exp_lat, input string name);
    int n;
    n = 0;
    while (cur_out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cur_out_valid !== 1'b1 || (cyc - acc) != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d expected %0d (valid=%b)", name, cyc - acc, exp_lat, cur_out_valid);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({in_ready_a[s], out_valid_a[s], busy_a[s], out_data_a[s]} !== 131'd0) begin
        errors++;
        $display("FAIL reset_state lanes=%0d got rdy=%b vld=%b busy=%b data=%h expected all 0",
                 lanes_of(2'(s)), in_ready_a[s], out_valid_a[s], busy_a[s], out_data_a[s]);
      end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (in_ready_a[s] !== 1'b1 || busy_a[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release lanes=%0d got rdy=%b busy=%b expected rdy=1 busy=0",
                 lanes_of(2'(s)), in_ready_a[s], busy_a[s]);
      end
    end
  endtask

  task automatic test_zero_block();
    int acc;
    sel = 2'd0;
    send_block('0, ALL63, acc);
    wait_out(acc, 4, "zero");
    checks++;
    if (cur_out_data !== ALL63) begin
      errors++;
      $display("FAIL zero_data got %h expected %h", cur_out_data, ALL63);
    end
    drain("zero");
  endtask

  task automatic test_fips();
    int acc;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      send_block(FIPS_IN, FIPS_OUT, acc);
      wait_out(acc, 16 / lanes_of(sel), "fips");
      checks++;
      if (cur_out_data !== FIPS_OUT) begin
        errors++;
        $display("FAIL fips_data lanes=%0d got %h expected %h", lanes_of(sel), cur_out_data, FIPS_OUT);
      end
      drain("fips");
    end
    sel = 2'd0;
  endtask

  task automatic test_backpressure();
    int acc;
    sel = 2'd0;
    out_ready = 1'b0;
    send_block(ALL53, ALLED, acc);
    wait_out(acc, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({cur_out_valid, cur_in_ready, cur_out_data} !== {1'b1, HOLD_IN_RDY, ALLED}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b data=%h expected vld=1 rdy=%b data=%h",
                 i, cur_out_valid, cur_in_ready, cur_out_data, HOLD_IN_RDY, ALLED);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b pending=%0d expected vld=0 rdy=1 busy=0 pending=0",
               cur_out_valid, cur_in_ready, cur_busy, exp_q.size());
    end
  endtask

  task automatic test_reset_midblock();
    int acc;
    sel = 2'd0;
    out_ready = 1'b1;
    send_block(ALL53, ALLED, acc);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (cur_out_valid !== 1'b0 || cur_busy !== 1'b0 || cur_out_data !== 128'd0) begin
      errors++;
      $display("FAIL midrst_async got vld=%b busy=%b data=%h expected vld=0 busy=0 data=0",
               cur_out_valid, cur_busy, cur_out_data);
    end
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_in_ready !== 1'b1 || cur_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got rdy=%b vld=%b expected rdy=1 vld=0", cur_in_ready, cur_out_valid);
    end
    send_block('0, ALL63, acc);
    drain("midrst");
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    sel = 2'd0;
    out_ready = 1'b1;
    send_block('0, ALL63, acc1);
    send_block(ALL53, ALLED, acc2);
    checks++;
    if (acc2 - acc1 != B2B_GAP) begin
      errors++;
      $display("FAIL b2b_spacing got %0d expected %0d", acc2 - acc1, B2B_GAP);
    end
    drain("b2b");
  endtask

  task automatic test_all_bytes();
    int acc;
    logic [127:0] d;
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(b * 16 + i);
        send_block(d, ref_sub(d), acc);
      end
      drain("allbytes");
    end
    sel = 2'd0;
  endtask

  task automatic test_overlap_wait();
    int acc;
    sel = 2'd0;
    out_ready = 1'b0;
    send_block('0, ALL63, acc);
`ifdef SUBBYTES_OVERLAP_EN
    send_block(ALL53, ALLED, acc);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({cur_out_valid, cur_busy, cur_in_ready, cur_out_data} !== {1'b1, 1'b1, 1'b0, ALL63}) begin
      errors++;
      $display("FAIL ovl_wait got vld=%b busy=%b rdy=%b data=%h expected vld=1 busy=1 rdy=0 data=%h",
               cur_out_valid, cur_busy, cur_in_ready, cur_out_data, ALL63);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cur_out_valid, cur_busy, cur_out_data} !== {1'b1, 1'b0, ALLED}) begin
      errors++;
      $display("FAIL ovl_reload got vld=%b busy=%b data=%h expected vld=1 busy=0 data=%h",
               cur_out_valid, cur_busy, cur_out_data, ALLED);
    end
    @(posedge clk); #1;
    checks++;
    if (cur_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovl_clear got vld=%b expected 0", cur_out_valid);
    end
`else
    wait_out(acc, 4, "hold");
    in_valid_a[sel] = 1'b1;
    in_data_a[sel]  = ALL53;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (cur_in_ready !== 1'b0 || cur_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_block cycle=%0d got rdy=%b vld=%b expected rdy=0 vld=1", i, cur_in_ready, cur_out_valid);
      end
      @(posedge clk); #1;
    end
    in_valid_a[sel] = 1'b0;
    out_ready = 1'b1;
    send_block(ALL53, ALLED, acc);
`endif
    out_ready = 1'b1;
    drain("ovl");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_ready = 1'b1;
    sel = 2'd0;
    for (int s = 0; s < 3; s++) begin
      in_valid_a[s] = 1'b0;
      in_data_a[s]  = '0;
    end
    test_reset();
    test_zero_block();
    test_fips();
    test_backpressure();
    test_reset_midblock();
    test_back_to_back();
    test_all_bytes();
    test_overlap_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Iterative SubBytes engine. Time-shares LANES `sbox` instances across the 16 bytes of a 128-bit AES state.
- Trades latency for area compared with the fully parallel 16-sbox SubBytes datapath.
- Sits between the round-state register and ShiftRows in area-constrained AES cores.
- Valid/ready handshake on both sides.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- NSTEP, 16/LANES (localparam), RUN cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  engine can accept a block
- in_data  input  128  state to substitute
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state
- busy  output  1  high in RUN or WAIT

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is asserted, 1 after release; out_valid=0; out_data=0; busy=0; step counter=0; work register=0. Reset mid-block discards the block; no partial output appears.
- Lane mapping:
  - Step k substitutes work[(k*LANES*8) +: LANES*8].
  - Lane j feeds byte k*LANES+j through `sbox` instance j.
  - Step 0 is bits [LANES*8-1:0] (LSB first).
  - Bytes not yet processed are held unchanged.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: work<=in_data, cnt<=0, go RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, write the LANES sbox outputs into the current slice; cnt<=cnt+1.
  - On the cycle cnt==NSTEP-1, the last slice is written and the engine leaves RUN.
  - cnt has width max(1, clog2(NSTEP)) and never wraps past NSTEP-1.
- Completion, base build (macro off):
  - After the last RUN cycle go HOLD: out_valid=1, out_data=work.
  - HOLD: busy=0, in_ready=0. On out_ready go IDLE and drop out_valid on the same edge.
  - Latency: out_valid rises NSTEP cycles after the accept edge.
  - Throughput: one block per NSTEP+2 cycles when out_ready is tied high.
- out_data is stable while out_valid=1 and out_ready=0. out_valid never drops without out_ready.
- in_data is sampled only on the accept edge. Later changes to in_data are ignored.
- LANES=16: RUN lasts one cycle (NSTEP=1).

Optional Feature:
- Macro: SUBBYTES_OVERLAP_EN.
- Macro defined:
  - A separate output register (out_data/out_valid) decouples the engine. States are IDLE, RUN, WAIT; there is no HOLD.
  - Output slot counts as free when out_valid==0 or out_ready==1.
  - At the last RUN cycle: if the slot is free, load the output register with the final work value (last slice included) and go IDLE. Otherwise go WAIT with the result held in work.
  - WAIT: busy=1, in_ready=0. Load the output register and go IDLE when the slot is free.
  - Output register: out_valid clears on out_ready unless reloaded on the same edge.
  - A new block can be accepted while the previous result waits in the output register.
  - Throughput: one block per NSTEP+1 cycles with out_ready high.
  - Latency: NSTEP cycles, same as the base build.
- Macro undefined: single-buffer HOLD behaviour exactly as described in Behaviour.

Test Plan:
- Reset release, then in_data=0 accepted → out_data=0x63636363_63636363_63636363_63636363, out_valid rises 4 cycles after the accept edge (LANES=4).
- FIPS-197 vector in_data=0x193de3bea0f4e22b9ac68d2ae9f84808 → out_data=0xd42711aee0bf98f1b8b45de51e415230. Run with LANES=1, 4 and 16; latency must be 16, 4 and 1 cycles respectively.
- out_ready held 0 for 10 cycles after out_valid → out_data constant, in_ready=0 (base build), out_valid stays 1. Release → one handshake, then IDLE.
- Assert rst 2 cycles after accepting 0x53 in every byte → out_valid=0 and in_ready=1 after release. Next block 0x00.. produces 0x63.. with no trace of 0xED bytes.
- Back-to-back blocks 0x00.., 0x53.. with out_ready=1:
  - Outputs in order 0x63.., 0xED...
  - Accept spacing 6 cycles in the base build, 5 with SUBBYTES_OVERLAP_EN (LANES=4).
- SUBBYTES_OVERLAP_EN with out_ready=0 and two blocks sent → first result in out_data, engine enters WAIT holding the second. Raising out_ready delivers the second result on the following edge; no loss or duplication.
